// File: rtl/dma_rc_tracker_if.sv
// RC completion stream in, s2c FIFO stream out, grouped for the requester-completion tracker.
// The slave modport is the tracker's view; master is the view of whoever drives RC and sinks s2c.
interface dma_rc_tracker_if #(
  parameter int C_BUS_DATA_WIDTH  = 256,
  parameter int C_BUS_KEEP_WIDTH  = C_BUS_DATA_WIDTH/32,
  parameter int C_RC_TUSER_WIDTH  = 75,
  parameter int C_RC_TREADY_WIDTH = 22
);
  logic [C_BUS_DATA_WIDTH-1:0]  S_AXIS_RC_TDATA;
  logic [C_RC_TUSER_WIDTH-1:0]  S_AXIS_RC_TUSER;
  logic                         S_AXIS_RC_TLAST;
  logic [C_BUS_KEEP_WIDTH-1:0]  S_AXIS_RC_TKEEP;
  logic                         S_AXIS_RC_TVALID;
  logic [C_RC_TREADY_WIDTH-1:0] S_AXIS_RC_TREADY;

  logic                         S2C_FIFO_TVALID;
  logic [C_BUS_DATA_WIDTH-1:0]  S2C_FIFO_TDATA;
  logic                         S2C_FIFO_TLAST;
  logic [C_BUS_KEEP_WIDTH-1:0]  S2C_FIFO_TKEEP;
  logic [7:0]                   S2C_FIFO_TTAG;
  logic                         S2C_FIFO_TREADY;

  modport slave (
    input  S_AXIS_RC_TDATA, S_AXIS_RC_TUSER, S_AXIS_RC_TLAST, S_AXIS_RC_TKEEP, S_AXIS_RC_TVALID,
    output S_AXIS_RC_TREADY,
    output S2C_FIFO_TVALID, S2C_FIFO_TDATA, S2C_FIFO_TLAST, S2C_FIFO_TKEEP, S2C_FIFO_TTAG,
    input  S2C_FIFO_TREADY
  );

  modport master (
    output S_AXIS_RC_TDATA, S_AXIS_RC_TUSER, S_AXIS_RC_TLAST, S_AXIS_RC_TKEEP, S_AXIS_RC_TVALID,
    input  S_AXIS_RC_TREADY,
    input  S2C_FIFO_TVALID, S2C_FIFO_TDATA, S2C_FIFO_TLAST, S2C_FIFO_TKEEP, S2C_FIFO_TTAG,
    output S2C_FIFO_TREADY
  );
endinterface

// File: rtl/dma_rc_tracker.sv
// Requester-completion tracker: forwards RC completion beats to the s2c FIFO and tracks
// received dwords per outstanding tag, raising completion / error / timeout pulses.
module dma_rc_tracker #(
  parameter int C_BUS_DATA_WIDTH  = 256,
  parameter int C_BUS_KEEP_WIDTH  = C_BUS_DATA_WIDTH/32,
  parameter int C_RC_TUSER_WIDTH  = 75,
  parameter int C_RC_TREADY_WIDTH = 22,
  parameter int C_WINDOW_SIZE     = 16,
  parameter int C_TIMEOUT_CYCLES  = 65535,
  parameter int C_FORWARD         = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  dma_rc_tracker_if.slave              bus,
  input  logic [C_WINDOW_SIZE-1:0]     BUSY_TAGS,
  input  logic [C_WINDOW_SIZE*11-1:0]  SIZE_TAGS,
  output logic [C_WINDOW_SIZE-1:0]     COMPLETED_TAGS,
  output logic [C_WINDOW_SIZE-1:0]     ERROR_TAGS,
  output logic [C_WINDOW_SIZE-1:0]     TIMEOUT_TAGS,
  output logic                         END_OF_TAG,
  output logic [7:0]                   LAST_TAG,
  output logic [63:0]                  BYTE_COUNT,
  output logic [31:0]                  UNEXPECTED_COUNT
);

  localparam int IDX_W = (C_WINDOW_SIZE > 1) ? $clog2(C_WINDOW_SIZE) : 1;
  localparam int TMR_W = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((C_TIMEOUT_CYCLES > 0) ? C_TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMR_EN = (C_TIMEOUT_CYCLES > 0);

  logic        rdy;
  logic        acc;
  logic        acc_sop;
  logic        acc_last;
  logic        sop_p0;

  logic [7:0]  in_tag;
  logic [10:0] in_dw;
  logic        in_err;
  logic        in_trk;

  logic [7:0]  hdr_tag_p1;
  logic [10:0] hdr_dw_p1;
  logic        hdr_err_p1;
  logic        hdr_trk_p1;

  logic [7:0]  cur_tag;
  logic [10:0] cur_dw;
  logic        cur_err;
  logic        cur_trk;
  logic        evt_last;

  logic        unused_bits;

  // ---- stage p0: handshake and header decode on the live beat ----
  assign rdy = (C_FORWARD != 0) ? bus.S2C_FIFO_TREADY : 1'b1;
  assign bus.S_AXIS_RC_TREADY = {C_RC_TREADY_WIDTH{rdy}};
  assign acc      = bus.S_AXIS_RC_TVALID && rdy;
  assign acc_sop  = acc && sop_p0;
  assign acc_last = acc && bus.S_AXIS_RC_TLAST;

  assign in_tag = bus.S_AXIS_RC_TDATA[71:64];
  assign in_dw  = bus.S_AXIS_RC_TDATA[42:32];
  assign in_err = (bus.S_AXIS_RC_TDATA[15:12] != 4'd0);
  assign in_trk = (in_tag < 8'(C_WINDOW_SIZE)) && BUSY_TAGS[in_tag[IDX_W-1:0]];

  // Header fields come from the live beat on SOP, from the latched copy afterwards,
  // so single-beat and multi-beat TLPs resolve through the same path.
  assign cur_tag = sop_p0 ? in_tag : hdr_tag_p1;
  assign cur_dw  = sop_p0 ? in_dw  : hdr_dw_p1;
  assign cur_err = sop_p0 ? in_err : hdr_err_p1;
  assign cur_trk = sop_p0 ? in_trk : hdr_trk_p1;
  assign evt_last = acc_last && cur_trk;

  generate
    if (C_FORWARD != 0) begin : g_fwd
      assign bus.S2C_FIFO_TVALID = bus.S_AXIS_RC_TVALID;
      assign bus.S2C_FIFO_TDATA  = bus.S_AXIS_RC_TDATA;
      assign bus.S2C_FIFO_TLAST  = bus.S_AXIS_RC_TLAST;
      assign bus.S2C_FIFO_TKEEP  = bus.S_AXIS_RC_TKEEP;
      assign bus.S2C_FIFO_TTAG   = sop_p0 ? in_tag : hdr_tag_p1;
    end else begin : g_sink
      assign bus.S2C_FIFO_TVALID = 1'b0;
      assign bus.S2C_FIFO_TDATA  = '0;
      assign bus.S2C_FIFO_TLAST  = 1'b0;
      assign bus.S2C_FIFO_TKEEP  = '0;
      assign bus.S2C_FIFO_TTAG   = 8'd0;
    end
  endgenerate

  assign unused_bits = ^{bus.S_AXIS_RC_TUSER, bus.S_AXIS_RC_TDATA, bus.S_AXIS_RC_TKEEP};

  // ---- stage p1: SOP tracking, header latch and global counters ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      sop_p0           <= 1'b1;
      hdr_err_p1       <= 1'b0;
      hdr_trk_p1       <= 1'b0;
      hdr_tag_p1       <= 8'd0;
      END_OF_TAG       <= 1'b0;
      LAST_TAG         <= 8'd0;
      BYTE_COUNT       <= 64'd0;
      UNEXPECTED_COUNT <= 32'd0;
    end else begin
      END_OF_TAG <= acc_last;
      if (acc) begin
        sop_p0 <= bus.S_AXIS_RC_TLAST;
      end
      if (acc_sop) begin
        hdr_err_p1 <= in_err;
        hdr_trk_p1 <= in_trk;
        hdr_tag_p1 <= in_tag;
        LAST_TAG   <= in_tag;
        if (!in_trk) begin
          UNEXPECTED_COUNT <= UNEXPECTED_COUNT + 32'd1;
        end else if (!in_err) begin
          BYTE_COUNT <= BYTE_COUNT + {51'd0, in_dw, 2'b00};
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (acc_sop) begin
      hdr_dw_p1 <= in_dw;
    end
  end

  // ---- stage p1: per-tag word counter, inactivity timer and result pulses ----
  genvar j;
  generate
    for (j = 0; j < C_WINDOW_SIZE; j++) begin : g_tag
      logic [10:0]      wcnt;
      logic [TMR_W-1:0] tmr;
      logic             tflag;
      logic             comp_q;
      logic             err_q;
      logic             to_q;
      logic [10:0]      size;
      logic [11:0]      sum;
      logic             hit_last;
      logic             hit_sop;
      logic             tmr_end;

      assign size     = SIZE_TAGS[11*j +: 11];
      assign sum      = {1'b0, wcnt} + {1'b0, cur_dw};
      assign hit_last = evt_last && (cur_tag == 8'(j));
      assign hit_sop  = acc_sop && in_trk && (in_tag == 8'(j));
      assign tmr_end  = TMR_EN && !tflag && (tmr == TMR_LAST);

      // Error outranks completion, and both outrank a timeout landing in the same
      // cycle; a suppressed timeout stays armed and fires on the next cycle.
      always_ff @(posedge CLK) begin
        if (RST || !BUSY_TAGS[j]) begin
          wcnt   <= 11'd0;
          tmr    <= '0;
          tflag  <= 1'b0;
          comp_q <= 1'b0;
          err_q  <= 1'b0;
          to_q   <= 1'b0;
        end else begin
          comp_q <= 1'b0;
          err_q  <= 1'b0;
          to_q   <= 1'b0;
          if (hit_last) begin
            if (cur_err) begin
              err_q <= 1'b1;
              wcnt  <= 11'd0;
            end else if (sum >= {1'b0, size}) begin
              comp_q <= 1'b1;
              wcnt   <= 11'd0;
            end else begin
              wcnt <= sum[10:0];
            end
          end else if (tmr_end) begin
            to_q  <= 1'b1;
            tflag <= 1'b1;
            wcnt  <= 11'd0;
          end
          if (hit_sop) begin
            tmr <= '0;
          end else if (TMR_EN && !tflag && !tmr_end) begin
            tmr <= tmr + TMR_W'(1);
          end
        end
      end

      assign COMPLETED_TAGS[j] = comp_q;
      assign ERROR_TAGS[j]     = err_q;
      assign TIMEOUT_TAGS[j]   = to_q;
    end
  endgenerate

endmodule

// File: tb/tb_dma_rc_tracker.sv
// Directed bench for dma_rc_tracker: a vector table for the streaming cases plus
// hand-written sequences for timeout and reset mid-TLP.
module tb_dma_rc_tracker;
  localparam int DW  = 256;
  localparam int KW  = DW/32;
  localparam int UW  = 75;
  localparam int RW  = 22;
  localparam int WIN = 16;
  localparam int TO  = 100;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [WIN-1:0]     BUSY_TAGS;
  logic [WIN*11-1:0]  SIZE_TAGS;
  logic [WIN-1:0]     COMPLETED_TAGS;
  logic [WIN-1:0]     ERROR_TAGS;
  logic [WIN-1:0]     TIMEOUT_TAGS;
  logic               END_OF_TAG;
  logic [7:0]         LAST_TAG;
  logic [63:0]        BYTE_COUNT;
  logic [31:0]        UNEXPECTED_COUNT;

  int checks = 0;
  int errors = 0;

  dma_rc_tracker_if #(.C_BUS_DATA_WIDTH(DW), .C_BUS_KEEP_WIDTH(KW),
                      .C_RC_TUSER_WIDTH(UW), .C_RC_TREADY_WIDTH(RW)) bus ();

  dma_rc_tracker #(
    .C_BUS_DATA_WIDTH(DW), .C_BUS_KEEP_WIDTH(KW), .C_RC_TUSER_WIDTH(UW),
    .C_RC_TREADY_WIDTH(RW), .C_WINDOW_SIZE(WIN), .C_TIMEOUT_CYCLES(TO), .C_FORWARD(1)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .BUSY_TAGS(BUSY_TAGS), .SIZE_TAGS(SIZE_TAGS),
    .COMPLETED_TAGS(COMPLETED_TAGS), .ERROR_TAGS(ERROR_TAGS), .TIMEOUT_TAGS(TIMEOUT_TAGS),
    .END_OF_TAG(END_OF_TAG), .LAST_TAG(LAST_TAG),
    .BYTE_COUNT(BYTE_COUNT), .UNEXPECTED_COUNT(UNEXPECTED_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        vld;
    logic        last;
    logic        frdy;
    logic [10:0] dw;
    logic [3:0]  ec;
    logic [7:0]  tag;
    logic [7:0]  x_ttag;
    logic [15:0] x_comp;
    logic [15:0] x_err;
    logic        x_eot;
    logic [7:0]  x_ltag;
    logic [63:0] x_bytes;
    logic [31:0] x_unexp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vld, logic last, logic frdy, logic [10:0] dw,
                              logic [3:0] ec, logic [7:0] tag, logic [7:0] x_ttag,
                              logic [15:0] x_comp, logic [15:0] x_err, logic x_eot,
                              logic [7:0] x_ltag, logic [63:0] x_bytes, logic [31:0] x_unexp);
    vec_t v;
    v.vld = vld; v.last = last; v.frdy = frdy; v.dw = dw; v.ec = ec; v.tag = tag;
    v.x_ttag = x_ttag; v.x_comp = x_comp; v.x_err = x_err; v.x_eot = x_eot;
    v.x_ltag = x_ltag; v.x_bytes = x_bytes; v.x_unexp = x_unexp;
    return v;
  endfunction

  function automatic logic [DW-1:0] beat(int i, logic [10:0] dw, logic [3:0] ec, logic [7:0] tag);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[32*k +: 32] = 32'hC0DE0000 + 32'(i*16 + k);
    d[42:32] = dw;
    d[15:12] = ec;
    d[71:64] = tag;
    return d;
  endfunction

  task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic vld, logic last, logic frdy, logic [DW-1:0] d);
    bus.S_AXIS_RC_TVALID = vld;
    bus.S_AXIS_RC_TLAST  = last;
    bus.S_AXIS_RC_TDATA  = d;
    bus.S_AXIS_RC_TKEEP  = last ? 8'h0F : 8'hFF;
    bus.S_AXIS_RC_TUSER  = '0;
    bus.S2C_FIFO_TREADY  = frdy;
  endtask

  task automatic chk_regs(int idx, logic [15:0] comp, logic [15:0] err, logic eot,
                          logic [7:0] ltag, logic [63:0] bytes, logic [31:0] unexp);
    check("completed", idx, 64'(COMPLETED_TAGS), 64'(comp));
    check("error",     idx, 64'(ERROR_TAGS),     64'(err));
    check("timeout",   idx, 64'(TIMEOUT_TAGS),   64'd0);
    check("eot",       idx, 64'(END_OF_TAG),     64'(eot));
    check("last_tag",  idx, 64'(LAST_TAG),       64'(ltag));
    check("bytes",     idx, BYTE_COUNT,          bytes);
    check("unexp",     idx, 64'(UNEXPECTED_COUNT), 64'(unexp));
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [63:0]   b;
    vec_t          v;

    BUSY_TAGS = 16'h002C;                  // tags 2, 3, 5
    SIZE_TAGS = '0;
    SIZE_TAGS[11*2 +: 11] = 11'd32;
    SIZE_TAGS[11*3 +: 11] = 11'd16;
    SIZE_TAGS[11*5 +: 11] = 11'd256;
    drive(1'b0, 1'b0, 1'b1, '0);

    // single completion: tag 3, 16 dwords over two beats
    vecs.push_back(mk(1,0,1, 16,0,8'd3,    8'd3, 16'h0,16'h0,0, 8'd3, 64'd64, 0));
    vecs.push_back(mk(1,1,1,  5,0,8'h2A,   8'd3, 16'h0008,16'h0,1, 8'd3, 64'd64, 0));
    vecs.push_back(mk(0,0,1,  0,0,8'd0,    8'd0, 16'h0,16'h0,0, 8'd3, 64'd64, 0));
    // split completion: tag 5, four TLPs of 64 dwords, FIFO ready toggling
    for (int n = 1; n <= 4; n++) begin
      b = 64'd64 + 64'(256*(n-1));
      vecs.push_back(mk(1,0,0, 64,0,8'd5,  8'd5, 16'h0,16'h0,0, (n==1) ? 8'd3 : 8'd5, b, 0));
      vecs.push_back(mk(1,0,1, 64,0,8'd5,  8'd5, 16'h0,16'h0,0, 8'd5, b+256, 0));
      vecs.push_back(mk(1,1,0,  7,0,8'h2A, 8'd5, 16'h0,16'h0,0, 8'd5, b+256, 0));
      vecs.push_back(mk(1,1,1,  7,0,8'h2A, 8'd5, (n==4) ? 16'h0020 : 16'h0,16'h0,1, 8'd5, b+256, 0));
    end
    vecs.push_back(mk(0,0,1,  0,0,8'd0,    8'd0, 16'h0,16'h0,0, 8'd5, 64'd1088, 0));
    // error completion: tag 2, single beat, code 1
    vecs.push_back(mk(1,1,1, 32,1,8'd2,    8'd2, 16'h0,16'h0004,1, 8'd2, 64'd1088, 0));
    vecs.push_back(mk(0,0,1,  0,0,8'd0,    8'd0, 16'h0,16'h0,0, 8'd2, 64'd1088, 0));
    // unexpected: tag 20 (out of window) then tag 4 (not busy, two beats)
    vecs.push_back(mk(1,1,1,  8,0,8'd20,   8'd20, 16'h0,16'h0,1, 8'd20, 64'd1088, 1));
    vecs.push_back(mk(1,0,1,  8,0,8'd4,    8'd4,  16'h0,16'h0,0, 8'd4,  64'd1088, 2));
    vecs.push_back(mk(1,1,1,  3,0,8'h2A,   8'd4,  16'h0,16'h0,1, 8'd4,  64'd1088, 2));
    vecs.push_back(mk(0,0,1,  0,0,8'd0,    8'd0,  16'h0,16'h0,0, 8'd4,  64'd1088, 2));
    // accumulation across single-beat TLPs: 10 + 6 dwords against size 16
    vecs.push_back(mk(1,1,1, 10,0,8'd3,    8'd3, 16'h0,16'h0,1, 8'd3, 64'd1128, 2));
    vecs.push_back(mk(1,1,1,  6,0,8'd3,    8'd3, 16'h0008,16'h0,1, 8'd3, 64'd1152, 2));
    vecs.push_back(mk(0,0,1,  0,0,8'd0,    8'd0, 16'h0,16'h0,0, 8'd3, 64'd1152, 2));

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // reset state
    chk_regs(-1, 16'h0, 16'h0, 1'b0, 8'd0, 64'd0, 32'd0);
    check("ttag_rst", -1, 64'(bus.S2C_FIFO_TTAG), 64'd0);
    check("tready_hi", -1, 64'(bus.S_AXIS_RC_TREADY), 64'h3FFFFF);
    bus.S2C_FIFO_TREADY = 1'b0;
    #1 check("tready_lo", -1, 64'(bus.S_AXIS_RC_TREADY), 64'd0);
    bus.S2C_FIFO_TREADY = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      v = vecs[i];
      d = beat(i, v.dw, v.ec, v.tag);
      drive(v.vld, v.last, v.frdy, d);
      #3;
      check("tready",  i, 64'(bus.S_AXIS_RC_TREADY), v.frdy ? 64'h3FFFFF : 64'd0);
      check("s2c_vld", i, 64'(bus.S2C_FIFO_TVALID), 64'(v.vld));
      check("s2c_lst", i, 64'(bus.S2C_FIFO_TLAST),  64'(v.last));
      check("s2c_kp",  i, 64'(bus.S2C_FIFO_TKEEP),  v.last ? 64'h0F : 64'hFF);
      checks++;
      if (bus.S2C_FIFO_TDATA !== d) begin
        errors++;
        $display("FAIL s2c_data[%0d]: got %0h expected %0h", i, bus.S2C_FIFO_TDATA, d);
      end
      if (v.vld) check("ttag", i, 64'(bus.S2C_FIFO_TTAG), 64'(v.x_ttag));
      @(posedge CLK); #1;
      chk_regs(i, v.x_comp, v.x_err, v.x_eot, v.x_ltag, v.x_bytes, v.x_unexp);
    end

    // timeout: only tag 7 busy, no traffic; one pulse at cycle 100, again after re-arm
    drive(1'b0, 1'b0, 1'b1, '0);
    for (int r = 0; r < 2; r++) begin
      BUSY_TAGS = 16'h0080;
      for (int k = 1; k <= 130; k++) begin
        @(posedge CLK); #1;
        check("to_pulse", 1000*r + k, 64'(TIMEOUT_TAGS), (k == TO) ? 64'h80 : 64'd0);
      end
      BUSY_TAGS = 16'h0000;
      repeat (3) @(posedge CLK);
      #1;
    end

    // reset during beat 2 of a 4-beat TLP for tag 3
    BUSY_TAGS = 16'h0008;
    drive(1'b1, 1'b0, 1'b1, beat(90, 11'd16, 4'd0, 8'd3));
    @(posedge CLK); #1;
    check("mid_bytes", 90, BYTE_COUNT, 64'd1216);
    drive(1'b1, 1'b0, 1'b1, beat(91, 11'd9, 4'd0, 8'h2A));
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk_regs(91, 16'h0, 16'h0, 1'b0, 8'd0, 64'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, beat(92, 11'd16, 4'd0, 8'd3));
    #3 check("ttag_hdr", 92, 64'(bus.S2C_FIFO_TTAG), 64'd3);
    @(posedge CLK); #1;
    chk_regs(92, 16'h0008, 16'h0, 1'b1, 8'd3, 64'd64, 32'd0);
    drive(1'b0, 1'b0, 1'b1, '0);
    @(posedge CLK); #1;
    chk_regs(93, 16'h0, 16'h0, 1'b0, 8'd3, 64'd64, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_rc_tracker.md
# dma_rc_tracker

Parametrised requester-completion tracker for the DMA engine. It sits between the PCIe RC AXI-Stream interface and the s2c FIFO. It forwards completion beats with backpressure and tracks received dwords per outstanding tag against the descriptor's requested size. It reports per-tag completion, error and timeout pulses, and keeps byte and unexpected-completion counters.

## Interface
- C_BUS_DATA_WIDTH, 256, RC/s2c data width in bits (128, 256 or 512).
- C_BUS_KEEP_WIDTH, C_BUS_DATA_WIDTH/32, keep width, one bit per dword.
- C_RC_TUSER_WIDTH, 75, RC tuser width.
- C_RC_TREADY_WIDTH, 22, RC tready width; all bits are driven identically.
- C_WINDOW_SIZE, 16, number of tracked tags (2..64); tags 0..C_WINDOW_SIZE-1.
- C_TIMEOUT_CYCLES, 65535, per-tag inactivity timeout in cycles; 0 disables timeouts.
- C_FORWARD, 1, 1 = forward beats to the s2c FIFO; 0 = sink mode.
- CLK  in  1  single clock; everything is posedge.
- RST  in  1  synchronous, active-high reset.
- S_AXIS_RC_TDATA/TUSER/TLAST/TKEEP/TVALID  in  per params  RC stream; straddle is not supported, and the header occupies dwords 0-2 of the first beat.
- S_AXIS_RC_TREADY  out  C_RC_TREADY_WIDTH  RC ready.
- S2C_FIFO_TVALID/TDATA/TLAST/TKEEP  out  per params  forwarded stream.
- S2C_FIFO_TTAG  out  8  tag of the TLP currently being forwarded.
- S2C_FIFO_TREADY  in  1  FIFO ready.
- BUSY_TAGS  in  C_WINDOW_SIZE  tag outstanding.
- SIZE_TAGS  in  C_WINDOW_SIZE*11  expected dwords per tag; tag j occupies [11j+10:11j].
- COMPLETED_TAGS / ERROR_TAGS / TIMEOUT_TAGS  out  C_WINDOW_SIZE  one-cycle pulses.
- END_OF_TAG  out  1  pulse, one cycle after any accepted TLAST.
- LAST_TAG  out  8  tag of the most recently started TLP.
- BYTE_COUNT  out  64  cumulative payload bytes counted.
- UNEXPECTED_COUNT  out  32  completions for a tag that is out of window or not busy.

## Operation
- **Header fields, first beat only:**
  - dword count = TDATA[42:32]
  - error code = TDATA[15:12]
  - tag = TDATA[71:64]
- **SOP tracking:** an SOP flag is set at reset and after each accepted TLAST, and cleared on any other accepted beat. Header fields are latched on an accepted SOP beat.
- **Accept:** an accepted beat is TVALID && TREADY.
- **Forward mode (C_FORWARD=1):**
  - TREADY = all-ones & S2C_FIFO_TREADY.
  - S2C_FIFO_TVALID = TVALID.
  - TDATA, TLAST and TKEEP pass through combinationally.
  - S2C_FIFO_TTAG = the header tag on the SOP beat, otherwise the latched tag.
- **Sink mode (C_FORWARD=0):** TREADY is all-ones and all S2C outputs are 0.
- **Per-tag state j:** 11-bit word counter, timeout timer, timed-out flag.
- **Accepted SOP with tag j < C_WINDOW_SIZE and BUSY_TAGS[j]=1:**
  - If the error code is nonzero, the TLP is an error TLP.
  - Otherwise add the dword count to BYTE_COUNT (×4).
  - Restart the timer.
- **Accepted SOP, any other tag:** UNEXPECTED_COUNT++. There is no change to tag state and no BYTE_COUNT change. The beats are still forwarded.
- **At the accepted TLAST beat of a tracked TLP:**
  - Error TLP: pulse ERROR_TAGS[j] and clear the counter.
  - Else if counter + dwords ≥ SIZE_TAGS[j]: pulse COMPLETED_TAGS[j] and clear the counter.
  - Else: counter += dwords.
  - All arithmetic is 12-bit to avoid wrap.
- **TLP lengths:** single-beat TLPs (SOP and TLAST on the same beat) are handled identically to multi-beat TLPs.
- **Timeout:**
  - The timer counts while BUSY_TAGS[j]=1 and the timed-out flag is clear.
  - When it reaches C_TIMEOUT_CYCLES: pulse TIMEOUT_TAGS[j] once, set the flag, clear the counter.
  - The flag and timer clear when BUSY_TAGS[j] falls.
- **BUSY_TAGS[j]=0:** counter, timer and flag are held at 0.
- **Simultaneous events, same tag, same cycle:** completion beats error? No: error beats completion, and both beat timeout. Only one pulse is issued per tag per cycle.

## Timing
- **Reset values:**
  - All pulses 0.
  - LAST_TAG=0, BYTE_COUNT=0, UNEXPECTED_COUNT=0, S2C_FIFO_TTAG=0.
  - SOP flag = 1.
  - TREADY follows S2C_FIFO_TREADY in forward mode and is all-ones in sink mode.
- **Data path:** zero-latency combinational pass-through.
- **Registered outputs:**
  - COMPLETED/ERROR/TIMEOUT_TAGS and END_OF_TAG are registered and assert exactly one cycle after the triggering TLAST beat (or timer terminal count).
  - LAST_TAG updates the cycle after an accepted SOP.
  - BYTE_COUNT and UNEXPECTED_COUNT update the cycle after an accepted SOP.
- **Stalls:** no state advances on a beat with TVALID && !TREADY.
- **Reset mid-TLP:** all state is discarded. The next accepted beat is treated as an SOP.
- **Counter wrap:** BYTE_COUNT and UNEXPECTED_COUNT wrap modulo 2^width.

## Test plan
- **Single completion:** tag 3 busy, SIZE=16; one TLP with dwords=16 over 2 beats -> COMPLETED_TAGS=0x0008 for one cycle, 1 cycle after TLAST; BYTE_COUNT=64.
- **Split completion:** tag 5, SIZE=256; four TLPs of 64 dwords with FIFO ready toggling every cycle -> no pulse after TLPs 1-3; pulse after TLP 4; data out equals data in beat-for-beat with TTAG=5.
- **Error completion:** tag 2, SIZE=32; TLP with error code 0x1, dwords=32 -> ERROR_TAGS[2] pulses, COMPLETED_TAGS[2] stays 0, BYTE_COUNT unchanged.
- **Unexpected tag:** tag 20 with C_WINDOW_SIZE=16, and busy=0 tag 4 -> UNEXPECTED_COUNT=2, no tag pulses, beats forwarded.
- **Timeout:** C_TIMEOUT_CYCLES=100, tag 7 busy with no traffic -> TIMEOUT_TAGS[7] pulses exactly once at cycle 100; after BUSY drops and rises again, it pulses again 100 cycles later.
- **Reset mid-TLP:** RST for 1 cycle during beat 2 of a 4-beat TLP -> outputs are at reset values and the next beat is parsed as a header.
